// File: rtl/sfx_pkg.sv
// rtl/sfx_pkg.sv - shared types and constants for the SFX trigger arbiter
// Purpose: arbiter FSM state type, width helper, default hold length and the
//          channel map used by the current game.
// Ports:   none (package).
package sfx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } sfx_state_t;

  localparam int SFX_HOLD_FRAMES_DEF = 8;

  localparam int CH_EAT = 0;
  localparam int CH_HIT = 1;
  localparam int CH_DIE = 2;

  // clog2 that never returns 0, so a 1-value field still gets one bit.
  function automatic int sfx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sfx_edge_sampler.sv
// rtl/sfx_edge_sampler.sv - per-channel frame sampler, edge detector and pending latch
// Purpose: samples one trigger level on frame_end, flags a 0->1 change between
//          frames and holds it as a pending request until granted or disabled.
// Ports:   clk, reset_n    - clock, asynchronous active-low reset
//          frame_end       - end-of-frame strobe (sampling enable)
//          trig            - level event input
//          enable          - channel enable; low clears pending immediately
//          clear           - grant/drop acknowledge from the arbiter
//          pend            - pending request
module sfx_edge_sampler (
  input  logic clk,
  input  logic reset_n,
  input  logic frame_end,
  input  logic trig,
  input  logic enable,
  input  logic clear,
  output logic pend
);

  logic last;
  logic edge_det;

  assign edge_det = frame_end & trig & ~last & enable;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last <= 1'b0;
      pend <= 1'b0;
    end else begin
      if (frame_end) begin
        last <= trig;
      end
      // Disable beats a new edge; a new edge beats the grant clear so a
      // request arriving on the grant cycle is not lost.
      if (!enable) begin
        pend <= 1'b0;
      end else if (edge_det) begin
        pend <= 1'b1;
      end else if (clear) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sfx_trigger_arbiter.sv
// rtl/sfx_trigger_arbiter.sv - frame-sampled SFX trigger arbiter into one voice
// Purpose: detects per-frame rising edges on NUM_CH event inputs, arbitrates
//          pending requests by fixed priority (channel 0 highest) and holds the
//          granted voice for HOLD_FRAMES frames with preemption and retrigger.
// Ports:   clk, reset_n    - clock, asynchronous active-low reset
//          frame_end       - one-cycle end-of-frame strobe
//          trig_in         - level event inputs, one per channel
//          ch_enable       - per-channel enable mask
//          sound_start     - one-hot pulse when a channel (re)starts
//          sound_active    - voice playing
//          sound_id        - playing channel, held while idle
//          frames_left     - remaining frames, 0 when idle
module sfx_trigger_arbiter
  import sfx_pkg::*;
#(
  parameter  int NUM_CH      = 3,
  parameter  int HOLD_FRAMES = SFX_HOLD_FRAMES_DEF,
  parameter  int RETRIGGER   = 1,
  localparam int ID_W        = sfx_width(NUM_CH),
  localparam int HOLD_W      = sfx_width(HOLD_FRAMES + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_end,
  input  logic [NUM_CH-1:0] trig_in,
  input  logic [NUM_CH-1:0] ch_enable,
  output logic [NUM_CH-1:0] sound_start,
  output logic              sound_active,
  output logic [ID_W-1:0]   sound_id,
  output logic [HOLD_W-1:0] frames_left
);

  sfx_state_t        state, state_nxt;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] clr;
  logic [NUM_CH-1:0] start_nxt;
  logic [ID_W-1:0]   win;
  logic [ID_W-1:0]   id_nxt;
  logic [HOLD_W-1:0] fl_nxt;
  logic              any_pend;
  logic              arb_ok;
  logic              gnt;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sfx_edge_sampler u_sampler (
      .clk       (clk),
      .reset_n   (reset_n),
      .frame_end (frame_end),
      .trig      (trig_in[i]),
      .enable    (ch_enable[i]),
      .clear     (clr[i]),
      .pend      (pend[i])
    );
  end

  assign any_pend     = |pend;
  assign sound_active = (state == PLAY);
  // No grant on the cycle a start pulse is out: an edge landing on the grant
  // cycle re-sets pend, and granting it at once would pulse twice in a row.
  assign arb_ok       = ~|sound_start;

  always_comb begin
    win = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend[i]) begin
        win = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    id_nxt    = sound_id;
    fl_nxt    = frames_left;
    start_nxt = '0;
    clr       = '0;
    gnt       = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_pend && arb_ok) begin
          gnt = 1'b1;
        end
      end
      PLAY: begin
        if (RETRIGGER == 0 && pend[sound_id]) begin
          clr[sound_id] = 1'b1;
        end
        if (any_pend && arb_ok && win < sound_id) begin
          gnt = 1'b1;
        end else if (RETRIGGER != 0 && arb_ok && pend[sound_id] && ch_enable[sound_id]) begin
          gnt = 1'b1;
        end else if (!ch_enable[sound_id]) begin
          state_nxt = IDLE;
          fl_nxt    = '0;
        end else if (frame_end) begin
          if (frames_left == HOLD_W'(1)) begin
            state_nxt = IDLE;
            fl_nxt    = '0;
          end else begin
            fl_nxt = frames_left - HOLD_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // A grant (new, preempt or retrigger) reloads the counter and overrides
    // any decrement or end decided above.
    if (gnt) begin
      state_nxt = PLAY;
      id_nxt    = win;
      fl_nxt    = HOLD_W'(HOLD_FRAMES);
      start_nxt = NUM_CH'(1) << win;
      clr       = clr | start_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      sound_id    <= '0;
      frames_left <= '0;
      sound_start <= '0;
    end else begin
      state       <= state_nxt;
      sound_id    <= id_nxt;
      frames_left <= fl_nxt;
      sound_start <= start_nxt;
    end
  end

endmodule

// File: tb/tb_sfx_trigger_arbiter.sv
// tb/tb_sfx_trigger_arbiter.sv - directed scoreboard bench for sfx_trigger_arbiter
module tb_sfx_trigger_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       reset_n_b = 1'b0;
  logic       frame_end = 1'b0;
  logic [2:0] trig_in = 3'b000;
  logic [2:0] ch_enable = 3'b111;

  logic [2:0] sound_start, sound_start_b;
  logic       sound_active, sound_active_b;
  logic [1:0] sound_id, sound_id_b;
  logic [3:0] frames_left, frames_left_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cnt_b = 0;
  logic mon_en = 1'b0;

  typedef struct {
    int ch;
    int cyc;
  } exp_t;
  exp_t sb[$];

  sfx_trigger_arbiter #(.NUM_CH(3), .HOLD_FRAMES(8), .RETRIGGER(1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_end    (frame_end),
    .trig_in      (trig_in),
    .ch_enable    (ch_enable),
    .sound_start  (sound_start),
    .sound_active (sound_active),
    .sound_id     (sound_id),
    .frames_left  (frames_left)
  );

  sfx_trigger_arbiter #(.NUM_CH(3), .HOLD_FRAMES(8), .RETRIGGER(0)) dut_b (
    .clk          (clk),
    .reset_n      (reset_n_b),
    .frame_end    (frame_end),
    .trig_in      (trig_in),
    .ch_enable    (ch_enable),
    .sound_start  (sound_start_b),
    .sound_active (sound_active_b),
    .sound_id     (sound_id_b),
    .frames_left  (frames_left_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int ch, input int at);
    exp_t e;
    e.ch  = ch;
    e.cyc = at;
    sb.push_back(e);
  endtask

  // One frame: strobe frame_end for a cycle, then three quiet cycles.
  task automatic frame(input logic [2:0] t, input int ch);
    @(negedge clk);
    trig_in   = t;
    frame_end = 1'b1;
    if (ch >= 0) push_exp(ch, cyc + 2);
    @(negedge clk);
    frame_end = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Scoreboard consumer for the RETRIGGER=1 instance.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sound_start !== 3'b000) begin
        if (sb.size() == 0) begin
          chk("unexpected_start", 32'(sound_start), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("start_vec", 32'(sound_start), 32'(1) << e.ch);
          chk("start_cyc", 32'(cyc), 32'(e.cyc));
          chk("start_id", 32'(sound_id), 32'(e.ch));
          chk("start_frames_left", 32'(frames_left), 32'd8);
        end
      end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
        chk("missing_start_ch", 32'(sound_start), 32'(1) << sb[0].ch);
        void'(sb.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (sound_start_b !== 3'b000) cnt_b <= cnt_b + 1;
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_start", 32'(sound_start), 32'd0);
    chk("rst_active", 32'(sound_active), 32'd0);
    chk("rst_id", 32'(sound_id), 32'd0);
    chk("rst_frames_left", 32'(frames_left), 32'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Single edge on ch0, then exactly 8 frame_ends to completion.
    frame(3'b001, 0);
    chk("single_active", 32'(sound_active), 32'd1);
    frame(3'b000, -1);
    repeat (6) frame(3'b000, -1);
    chk("single_fl_last", 32'(frames_left), 32'd1);
    chk("single_active_last", 32'(sound_active), 32'd1);
    frame(3'b000, -1);
    chk("single_end_active", 32'(sound_active), 32'd0);
    chk("single_end_fl", 32'(frames_left), 32'd0);
    chk("single_id_hold", 32'(sound_id), 32'd0);

    // Simultaneous ch1+ch2: ch1 first, ch2 after one idle cycle.
    frame(3'b110, 1);
    repeat (7) frame(3'b110, -1);
    @(negedge clk);
    trig_in   = 3'b110;
    frame_end = 1'b1;
    push_exp(2, cyc + 2);
    @(negedge clk);
    frame_end = 1'b0;
    chk("sim_idle_gap", 32'(sound_active), 32'd0);
    @(negedge clk);
    chk("sim_second_active", 32'(sound_active), 32'd1);
    repeat (2) @(negedge clk);

    // Preempt ch2 at frames_left=5 by ch0.
    repeat (3) frame(3'b110, -1);
    chk("pre_fl", 32'(frames_left), 32'd5);
    chk("pre_id", 32'(sound_id), 32'd2);
    frame(3'b111, 0);
    chk("preempt_id", 32'(sound_id), 32'd0);
    chk("preempt_fl", 32'(frames_left), 32'd8);
    repeat (8) frame(3'b111, -1);
    chk("preempt_end", 32'(sound_active), 32'd0);
    frame(3'b111, -1);
    chk("no_resume", 32'(sound_active), 32'd0);

    // Level held 20 frames gives one start; mid-frame glitches are ignored.
    frame(3'b000, -1);
    frame(3'b001, 0);
    repeat (19) frame(3'b001, -1);
    chk("level_idle", 32'(sound_active), 32'd0);
    @(negedge clk);
    trig_in = 3'b101;
    repeat (2) @(negedge clk);
    trig_in = 3'b001;
    frame(3'b001, -1);
    chk("glitch_idle", 32'(sound_active), 32'd0);

    // Retrigger: both variants run side by side.
    @(negedge clk);
    reset_n_b = 1'b1;
    frame(3'b010, 1);
    repeat (5) frame(3'b010, -1);
    chk("rt_fl3", 32'(frames_left), 32'd3);
    chk("rt0_fl3", 32'(frames_left_b), 32'd3);
    frame(3'b000, -1);
    chk("rt0_fl2", 32'(frames_left_b), 32'd2);
    frame(3'b010, 1);
    chk("rt_reload", 32'(frames_left), 32'd8);
    chk("rt0_fl1", 32'(frames_left_b), 32'd1);
    chk("rt0_starts", 32'(cnt_b), 32'd1);
    frame(3'b010, -1);
    chk("rt_fl7", 32'(frames_left), 32'd7);
    chk("rt0_end", 32'(sound_active_b), 32'd0);

    // Disabling the playing channel ends the sound next cycle.
    @(negedge clk);
    ch_enable = 3'b101;
    @(negedge clk);
    chk("dis_active", 32'(sound_active), 32'd0);
    chk("dis_fl", 32'(frames_left), 32'd0);
    ch_enable = 3'b111;

    // Asynchronous reset mid-sound, input held through release.
    frame(3'b000, -1);
    frame(3'b100, 2);
    chk("pre_rst_active", 32'(sound_active), 32'd1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_active", 32'(sound_active), 32'd0);
    chk("arst_id", 32'(sound_id), 32'd0);
    chk("arst_fl", 32'(frames_left), 32'd0);
    chk("arst_start", 32'(sound_start), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    frame(3'b100, 2);
    chk("held_id", 32'(sound_id), 32'd2);
    repeat (8) frame(3'b100, -1);
    chk("held_end", 32'(sound_active), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sfx_trigger_arbiter.md
Name: sfx_trigger_arbiter

Overview:
- Parametrised successor to the per-frame collision-to-SFX trigger.
- Samples NUM_CH game-event inputs once per frame and detects rising edges (0 in previous frame, 1 in this frame).
- Latches detected edges as pending requests and arbitrates them by fixed priority into a single sound voice.
- Holds the voice for HOLD_FRAMES frames and supports preemption and retrigger.
- Sits between the game-logic collision detectors and the APU voice/envelope logic.

Parameters:
- NUM_CH, 3: number of trigger channels. Channel 0 has the highest priority. Legal range 2..16.
- HOLD_FRAMES, 8: frames a granted sound stays active. Legal range 1..255.
- RETRIGGER, 1: 1 = a new edge on the currently playing channel restarts it; 0 = that edge is discarded.
- ID_W, derived as clog2(NUM_CH): width of sound_id.
- HOLD_W, derived as clog2(HOLD_FRAMES+1): width of frames_left.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous, active-low reset.
- frame_end, input, 1: one-cycle strobe at the end of each video frame.
- trig_in, input, NUM_CH: level event inputs (collision flags).
- ch_enable, input, NUM_CH: per-channel enable mask.
- sound_start, output, NUM_CH: one-hot, one-cycle pulse when a channel's sound is (re)started.
- sound_active, output, 1: high while the voice is playing.
- sound_id, output, ID_W: index of the playing channel. Holds its last value while idle.
- frames_left, output, HOLD_W: remaining frames of the current sound. 0 when idle.

Behaviour:
- Reset (asynchronous, reset_n=0): sample regs, pending, sound_start, sound_active, sound_id, frames_left all 0; state IDLE.
- Reset mid-sound aborts the sound immediately with no completion pulse.
- An input held high through reset release is seen as an edge at the first frame_end.
- Sampling: only on cycles with frame_end=1.
  - edge[i] = trig_in[i] & ~last[i] & ch_enable[i].
  - last[i] <= trig_in[i].
  - Inputs between frame_end strobes are ignored.
- Pending: pend[i] is set on the cycle after an edge (T+1). It is cleared when channel i is granted, or on any cycle with ch_enable[i]=0. Set and clear in the same cycle → set wins for an edge, clear wins for disable.
- Arbitration: the lowest-index pending channel wins.
- IDLE:
  - If any pend=1 → grant. sound_start[win], sound_active, sound_id and frames_left=HOLD_FRAMES all take effect on the next cycle.
  - Latency from the frame_end edge cycle T to sound_start is exactly 2 clocks (pulse at T+2).
  - Go to PLAY.
- PLAY:
  - Each frame_end decrements frames_left.
  - When frame_end arrives with frames_left==1: frames_left=0, sound_active=0 next cycle, go to IDLE.
  - Remaining pending requests are granted on the following cycle, giving one idle cycle between sounds.
- Preempt: in PLAY, pending on a channel with lower index than sound_id → regrant to that channel.
  - sound_start pulses, sound_id changes, frames_left reloads.
  - The preempted channel is not re-queued.
- Retrigger: pending on sound_id itself.
  - RETRIGGER=1: reload frames_left, pulse sound_start, clear pend.
  - RETRIGGER=0: clear pend with no effect on the sound.
- Lower-priority pending requests wait through PLAY and are served in priority order afterwards.
- Disabling the playing channel ends the sound on the next cycle (→ IDLE, frames_left=0).
- Grant, decrement and end events in the same cycle: preempt/retrigger beats end and decrement; reload ignores a coincident frame_end.
- sound_start is never asserted on two consecutive cycles for the same channel, and never has more than one bit set.

Decomposition:
- sfx_pkg:
  - state enum (IDLE, PLAY);
  - clog2-based width helper;
  - default HOLD_FRAMES constant;
  - channel index constants CH_EAT=0, CH_HIT=1, CH_DIE=2 for the current game.
- Sub-module sfx_edge_sampler: per-channel last/edge/pending logic, instantiated NUM_CH times via generate.
- Top level holds the arbiter, FSM and hold counter.

Test Plan:
- Single edge: trig_in=001 at frame_end cycle T → sound_start=001 at T+2, sound_id=0, frames_left=8. Exactly 8 frame_ends later, sound_active=0.
- Simultaneous: trig_in 000→110 at one frame_end → ch1 plays for 8 frames, then after 1 idle cycle sound_start=100, sound_id=2.
- Preempt: ch2 playing with frames_left=5, ch0 edge → sound_start=001, sound_id=0, frames_left=8. ch2 does not resume.
- Retrigger: ch1 playing with frames_left=3, ch1 falls then rises over two frames → RETRIGGER=1 gives reload to 8 and a pulse; RETRIGGER=0 leaves the count running (3→2→1) with no pulse.
- Level held: trig_in[0]=1 held for 20 frames → exactly one sound_start. Input changes between frame_end strobes produce no start.
- Disable/reset: ch_enable[1]=0 while ch1 plays → sound_active=0 next cycle. reset_n pulsed low mid-sound → all outputs 0 asynchronously.
